// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one external pipelined adder among N requesters.
// A tag pipe tracks which requester owns each in-flight addition so results return to their origin.
module adder_rr_arbiter #(
    parameter int W   = 64,
    parameter int N   = 4,
    parameter int LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req_valid,
    output logic [N-1:0]               req_ready,
    input  logic [N*W-1:0]             req_a,
    input  logic [N*W-1:0]             req_b,
    input  logic [N-1:0]               req_cin,
    input  logic [N-1:0]               cfg_mask,
    output logic [W-1:0]               add_a,
    output logic [W-1:0]               add_b,
    output logic                       add_cin,
    input  logic [W-1:0]               add_sum,
    input  logic                       add_cout,
    output logic [N-1:0]               rsp_valid,
    output logic [W-1:0]               rsp_sum,
    output logic                       rsp_cout,
    output logic [$clog2(LAT+3)-1:0]   inflight
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LAT + 3);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] grant_id;
    logic          grant_any;
    logic          tail_valid;
    logic [IW-1:0] tail_id;

    logic [W-1:0]  add_a_reg;
    logic [W-1:0]  add_b_reg;
    logic          add_cin_reg;
    logic [N-1:0]  rsp_valid_reg;
    logic [W-1:0]  rsp_sum_reg;
    logic          rsp_cout_reg;
    logic [CW-1:0] inflight_reg;

    // Scan from the pointer upward; index arithmetic wraps naturally because N is a power of 2.
    always_comb begin
        logic [IW-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_reg + IW'(k);
            if (!grant_any && req_valid[idx] && !cfg_mask[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
    end

    assign req_ready = grant_any ? (N'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg     <= '0;
            add_a_reg   <= '0;
            add_b_reg   <= '0;
            add_cin_reg <= 1'b0;
        end else if (grant_any) begin
            ptr_reg     <= grant_id + IW'(1);
            add_a_reg   <= req_a[grant_id*W +: W];
            add_b_reg   <= req_b[grant_id*W +: W];
            add_cin_reg <= req_cin[grant_id];
        end
    end

    // Tag stage gi is aligned with the adder's internal stage; stage LAT lines up with add_sum.
    for (genvar gi = 0; gi <= LAT; gi++) begin : g_tag
        logic          v_reg;
        logic [IW-1:0] id_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_reg <= 1'b0;
                end else begin
                    v_reg <= grant_any;
                end
                if (grant_any) begin
                    id_reg <= grant_id;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_reg <= 1'b0;
                end else begin
                    v_reg <= g_tag[gi-1].v_reg;
                end
                id_reg <= g_tag[gi-1].id_reg;
            end
        end
    end

    assign tail_valid = g_tag[LAT].v_reg;
    assign tail_id    = g_tag[LAT].id_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= '0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
        end else if (tail_valid) begin
            rsp_valid_reg <= N'(1) << tail_id;
            rsp_sum_reg   <= add_sum;
            rsp_cout_reg  <= add_cout;
        end else begin
            rsp_valid_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else if (grant_any && !tail_valid) begin
            inflight_reg <= inflight_reg + CW'(1);
        end else if (!grant_any && tail_valid) begin
            inflight_reg <= inflight_reg - CW'(1);
        end
    end

    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign add_cin   = add_cin_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign inflight  = inflight_reg;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized bench for adder_rr_arbiter with an external LAT-stage adder and a
// queue-based reference model of grants, response timing and in-flight count.
module tb_adder_rr_arbiter;

    localparam int W   = 64;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int CW  = $clog2(LAT + 3);

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic [N-1:0]     cfg_mask;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_cin;
    logic [W-1:0]     add_sum;
    logic             add_cout;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
    logic [CW-1:0]    inflight;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.W(W), .N(N), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .cfg_mask  (cfg_mask),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .inflight  (inflight)
    );

    // Shared adder: LAT register stages between add_a/add_b/add_cin and add_sum/add_cout.
    logic [W:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_sum  = add_pipe[LAT-1][W-1:0];
    assign add_cout = add_pipe[LAT-1][W];

    typedef struct {
        int         id;
        int         due;
        logic [W:0] res;
    } exp_t;

    exp_t        q[$];
    int          m_ptr    = 0;
    logic [N-1:0] m_rv    = '0;
    logic [W:0]  m_sum    = '0;
    int          edge_cnt = 0;
    int          total    = 0;
    int          bad      = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_cnt, got, exp);
        end
    endtask

    // One clock: check the combinational grant, clock it, update the model, check registered outputs.
    task automatic step();
        int   g;
        exp_t e;
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx] && !cfg_mask[idx]) g = idx;
            end
        end
        check_val("req_ready", 128'(req_ready), (g < 0) ? 128'd0 : (128'd1 << g));
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_rv  = '0;
            m_sum = '0;
        end else begin
            m_rv = '0;
            if (q.size() > 0 && q[0].due == edge_cnt) begin
                e     = q.pop_front();
                m_rv  = N'(1) << e.id;
                m_sum = e.res;
            end
            if (g >= 0) begin
                e.id  = g;
                e.due = edge_cnt + LAT + 1;
                e.res = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + (W+1)'(req_cin[g]);
                q.push_back(e);
                m_ptr = (g + 1) % N;
            end
        end
        #1;
        check_val("rsp_valid", 128'(rsp_valid), 128'(m_rv));
        check_val("rsp_sum", 128'(rsp_sum), 128'(m_sum[W-1:0]));
        check_val("rsp_cout", 128'(rsp_cout), 128'(m_sum[W]));
        check_val("inflight", 128'(inflight), 128'(q.size()));
        $display("edge=%0d rst=%0b valid=%b mask=%b ready=%b rsp_valid=%b sum=%0h cout=%0b inflight=%0d",
                 edge_cnt, rst, req_valid, cfg_mask, req_ready, rsp_valid, rsp_sum, rsp_cout, inflight);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = {$urandom, $urandom};
            req_b[i*W +: W] = {$urandom, $urandom};
            req_cin[i]      = 1'($urandom);
        end
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        cfg_mask  = '0;
        rand_ops();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        idle(2);

        // Single request: 5 + 7 + 1 from requester 0.
        req_a = '0; req_b = '0; req_cin = '0;
        req_a[0 +: W] = 64'd5;
        req_b[0 +: W] = 64'd7;
        req_cin[0]    = 1'b1;
        req_valid     = 4'b0001;
        step();
        idle(6);

        // Round-robin across all requesters.
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        idle(6);

        // Overflow from requester 2.
        req_a[2*W +: W] = '1;
        req_b[2*W +: W] = 64'd1;
        req_cin[2]      = 1'b0;
        req_valid       = 4'b0100;
        step();
        idle(6);

        // Requester 1 masked off.
        req_valid = '1;
        cfg_mask  = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step();
        end
        cfg_mask = '0;
        idle(6);

        // Reset while three operations are in flight.
        req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        idle(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(6);
        req_valid = '1;
        rand_ops();
        step();
        idle(6);

        // Random traffic with occasional resets and mask changes.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid = N'($urandom);
            cfg_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rst       = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter W, default 64, operand/sum width.
REQ-002 Parameter N, default 4, number of requesters (N >= 2, power of 2).
REQ-003 Parameter LAT, default 3, fixed latency in clock edges from add_a/add_b/add_cin to add_sum/add_cout of the shared pipelined adder.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N  per-requester request valid.
REQ-007 req_ready  output  N  per-requester grant, one-hot or zero.
REQ-008 req_a, req_b  input  N*W  operands, requester i at bits [i*W +: W].
REQ-009 req_cin  input  N  per-requester carry-in.
REQ-010 cfg_mask  input  N  1 = requester disabled, never granted.
REQ-011 add_a, add_b  output  W  registered operands to shared adder.
REQ-012 add_cin  output  1  registered carry-in to shared adder.
REQ-013 add_sum  input  W, add_cout  input  1  shared adder results.
REQ-014 rsp_valid  output  N  one-hot result strobe, routed to originating requester.
REQ-015 rsp_sum  output  W, rsp_cout  output  1  registered result.
REQ-016 inflight  output  clog2(LAT+3)  count of accepted, not yet responded operations.

Function
REQ-017 Grant: req_ready[i] combinational, asserted for exactly the first i with req_valid[i]=1 and cfg_mask[i]=0, searching from pointer ptr upward modulo N; all zero if none eligible.
REQ-018 Transfer occurs at an edge where req_valid[i] and req_ready[i] are both 1; at most one transfer per cycle.
REQ-019 On transfer from i: ptr <= (i+1) mod N; with no transfer ptr holds.
REQ-020 On transfer: add_a/add_b/add_cin <= selected req_a/req_b/req_cin; with no transfer they hold previous values.
REQ-021 Tag pipe: LAT+1 stages of {valid, id}; stage 0 loaded on each edge with {transfer, granted id}, {0, hold id} otherwise; shifts every edge, no stall.
REQ-022 Response: at the edge when the tag-pipe tail is valid, rsp_valid <= onehot(tail id), rsp_sum <= add_sum, rsp_cout <= add_cout; otherwise rsp_valid <= 0, rsp_sum/rsp_cout hold.
REQ-023 Latency: request accepted at edge E -> rsp_valid high for exactly one cycle after edge E+LAT+1.
REQ-024 Throughput: one accepted request per cycle sustained; responses return in acceptance order.
REQ-025 No response backpressure; requester must accept rsp in its strobe cycle.
REQ-026 inflight: +1 on transfer, -1 on response issue, unchanged when both or neither in same edge; max value LAT+1.
REQ-027 cfg_mask changes take effect on the same cycle's grant; in-flight operations of newly masked requesters still complete and respond.
REQ-028 req_valid may drop without transfer; no grant is held across cycles.
REQ-029 Pointer wrap: grant of N-1 sets ptr to 0.

Reset
REQ-030 rst=1 at an edge: ptr<=0, add_a/add_b<=0, add_cin<=0, all tag-pipe valid<=0, rsp_valid<=0, rsp_sum<=0, rsp_cout<=0, inflight<=0.
REQ-031 During rst=1 req_ready SHALL be all zero; operations in flight at reset are discarded, no responses emitted for them.

Verification
REQ-032 Single: after reset, req_valid=0001, a=5, b=7, cin=1 at edge E -> req_ready=0001, rsp_valid=0001, rsp_sum=13, rsp_cout=0 one cycle after E+4 (LAT=3); inflight 1 then 0.
REQ-033 Round-robin: req_valid=1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid sequence identical, each sum matching its requester's operands.
REQ-034 Overflow: a=all-ones, b=1, cin=0 from requester 2 -> rsp_valid=0100, rsp_sum=0, rsp_cout=1.
REQ-035 Mask: req_valid=1111, cfg_mask=0010 for 6 cycles -> grants 0,2,3,0,2,3; requester 1 never granted.
REQ-036 Reset mid-flight: 3 requests accepted on consecutive edges, rst=1 for one edge two cycles later -> no rsp_valid for any of them, inflight=0, next grant search starts at requester 0.
